div_restoring: RTL and testbench
================================

DIV_RESTORING -- requirements
Module: div_restoring

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  start request, sampled on the rising clk edge, honoured only in IDLE.
REQ-005 inbus  input  8  operand byte bus, sampled on the rising clk edge in the load states.
REQ-006 outbus  output  8  result byte bus, registered.
REQ-007 done  output  1  result-valid flag, registered; high on the two result cycles only.

Function
REQ-008 Operation SHALL be 16/8 unsigned restoring division.
- Dividend is {A,Q}, with A the high byte and Q the low byte.
- Divisor is M.
- Results: 8-bit quotient and 8-bit remainder.
REQ-009 FSM states SHALL be IDLE, LOAD_A, LOAD_Q, LOAD_M, DIVIDE, OUT_R, OUT_Q.
REQ-010 IDLE: enable=1 at an edge -> LOAD_A; otherwise stay in IDLE.
REQ-011 LOAD_A: next edge A <- inbus (9-bit A register, MSB cleared) -> LOAD_Q.
REQ-012 LOAD_Q: next edge Q <- inbus -> LOAD_M.
REQ-013 LOAD_M: next edge M <- inbus, iteration counter <- 8.
- If M==0 or A>=M (overflow), next state SHALL be OUT_R with an error flag set.
- Otherwise next state SHALL be DIVIDE.
REQ-014 DIVIDE SHALL complete one iteration per clock, 8 clocks total, then -> OUT_R.
- Shift {A,Q} left by one.
- T = A - {0,M} in 9 bits.
- If T is negative: A unchanged (restore) and Q[0]=0.
- Otherwise: A <- T and Q[0]=1.
- Decrement the counter.
REQ-015 OUT_R: outbus = A[7:0] (remainder), done=1, for exactly one cycle -> OUT_Q.
REQ-016 OUT_Q: outbus = Q (quotient), done=1, for exactly one cycle -> IDLE.
REQ-017 On overflow (REQ-013), outbus SHALL be 8'hFF in both OUT_R and OUT_Q; done behaves normally.
REQ-018 Latency: the first result cycle (OUT_R) SHALL begin 12 clock edges after the edge that samples enable.
- Normal case: 1+1+1+8+1 edges.
- Overflow case: the result SHALL appear 8 edges sooner.
REQ-019 outbus SHALL be 8'h00 and done SHALL be 0 in all states except OUT_R and OUT_Q.
REQ-020 enable SHALL be ignored in every state other than IDLE; there is no abort input.
REQ-021 The block SHALL expose an internal 8-bit control vector named c for hierarchical probing, decoded from the current state:
- c[0] load A, c[1] load Q, c[2] load M.
- c[3] shift, c[4] subtract, c[5] Q[0] set/restore select.
- c[6] drive remainder (high only in OUT_R).
- c[7] drive quotient (high only in OUT_Q).
- c SHALL be 0 in IDLE and during reset.

Reset
REQ-022 While rst_n=0 the FSM SHALL be IDLE and A, Q, M, the counter and the error flag SHALL be 0.
REQ-023 While rst_n=0, outbus SHALL be 8'h00 and done SHALL be 0.
REQ-024 Reset SHALL take effect asynchronously and SHALL abort any operation in progress, including mid-DIVIDE or mid-output.
REQ-025 After rst_n deasserts, the first rising edge SHALL evaluate IDLE; a new operation needs a fresh enable.

Verification
REQ-026 Pulse enable, then inbus 1, 4, 10 on successive cycles -> done for two cycles, outbus 0 (remainder) then 26 (quotient); 260/10.
REQ-027 Operands A=0, Q=100, M=7 -> outbus 2 then 14.
REQ-028 Boundaries:
- A=9, Q=255, M=10 -> outbus 9 then 255 (2559/10, maximum quotient).
- A=0, Q=255, M=1 -> outbus 0 then 255.
REQ-029 Overflow:
- A=10, Q=0, M=10 -> outbus FF, FF, with done for two cycles, 4 edges after enable.
- A=0, Q=5, M=0 -> outbus FF, FF.
REQ-030 Reset during DIVIDE -> outbus=0, done=0, and c=0 immediately.
- A following normal operation SHALL complete correctly.
- enable held high during DIVIDE SHALL be ignored.
- Check c[6] and c[7] each pulse for exactly one cycle, in order.

Source files
------------

// File: rtl/div_restoring.sv
// 16/8 unsigned restoring divider: operands arrive as three bytes (A, Q, M),
// remainder then quotient leave on outbus with done high for those two cycles.
module div_restoring (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] inbus,
   output logic [7:0] outbus,
   output logic       done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_A = 3'd1;
   localparam logic [2:0] S_LOAD_Q = 3'd2;
   localparam logic [2:0] S_LOAD_M = 3'd3;
   localparam logic [2:0] S_DIVIDE = 3'd4;
   localparam logic [2:0] S_OUT_R  = 3'd5;
   localparam logic [2:0] S_OUT_Q  = 3'd6;

   logic [2:0] state_q, state_d;
   logic [8:0] a_q, a_d;
   logic [7:0] q_q, q_d;
   logic [7:0] m_q, m_d;
   logic [3:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic [7:0] outbus_q, outbus_d;
   logic       done_q, done_d;

   // Control vector decoded from the current state, kept for hierarchical probing.
   logic [7:0] c;

   logic [8:0] a_sh;
   logic [7:0] q_sh;
   logic [8:0] t;

   assign a_sh = {a_q[7:0], q_q[7]};
   assign q_sh = {q_q[6:0], 1'b0};
   assign t    = a_sh - {1'b0, m_q};

   always_comb begin
      c      = 8'h00;
      c[0]   = (state_q == S_LOAD_A);
      c[1]   = (state_q == S_LOAD_Q);
      c[2]   = (state_q == S_LOAD_M);
      c[3]   = (state_q == S_DIVIDE);
      c[4]   = (state_q == S_DIVIDE);
      c[5]   = (state_q == S_DIVIDE);
      c[6]   = (state_q == S_OUT_R);
      c[7]   = (state_q == S_OUT_Q);
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_LOAD_A;
         end
         S_LOAD_A: begin
            a_d     = {1'b0, inbus};
            err_d   = 1'b0;
            state_d = S_LOAD_Q;
         end
         S_LOAD_Q: begin
            q_d     = inbus;
            state_d = S_LOAD_M;
         end
         S_LOAD_M: begin
            m_d   = inbus;
            cnt_d = 4'd8;
            // A >= M means the quotient cannot fit in 8 bits.
            if ((inbus == 8'h00) || (a_q >= {1'b0, inbus})) begin
               err_d   = 1'b1;
               state_d = S_OUT_R;
            end else begin
               state_d = S_DIVIDE;
            end
         end
         S_DIVIDE: begin
            if (t[8]) begin
               a_d = a_sh;
               q_d = q_sh;
            end else begin
               a_d = t;
               q_d = {q_q[6:0], 1'b1};
            end
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_OUT_R;
         end
         S_OUT_R: state_d = S_OUT_Q;
         S_OUT_Q: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Result registers follow the state by one edge.
   always_comb begin
      outbus_d = 8'h00;
      done_d   = 1'b0;
      if (state_q == S_OUT_R) begin
         outbus_d = err_q ? 8'hFF : a_q[7:0];
         done_d   = 1'b1;
      end else if (state_q == S_OUT_Q) begin
         outbus_d = err_q ? 8'hFF : q_q;
         done_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= 9'd0;
         q_q      <= 8'd0;
         m_q      <= 8'd0;
         cnt_q    <= 4'd0;
         err_q    <= 1'b0;
         outbus_q <= 8'h00;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         q_q      <= q_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         outbus_q <= outbus_d;
         done_q   <= done_d;
      end
   end

   assign outbus = outbus_q;
   assign done   = done_q;

endmodule

// File: tb/tb_div_restoring.sv
// Directed and random operand sequences for div_restoring, checked against
// plain integer division of {A,Q} by M.
module tb_div_restoring;
  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] inbus;
  logic [7:0] outbus;
  logic       done;

  int checks = 0;
  int errors = 0;

  div_restoring dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .inbus  (inbus),
    .outbus (outbus),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: 16/8 unsigned division, FF/FF when the quotient overflows.
  task automatic model(input logic [7:0] a, input logic [7:0] q, input logic [7:0] m,
                       output logic [7:0] rem, output logic [7:0] quo, output int lat);
    int dividend;
    dividend = a * 256 + q;
    if (m == 0 || a >= m) begin
      rem = 8'hFF; quo = 8'hFF; lat = 4;
    end else begin
      rem = 8'(dividend % m); quo = 8'(dividend / m); lat = 12;
    end
  endtask

  // Inputs change on falling edges; outputs are sampled on falling edges.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] q,
                        input logic [7:0] m, input bit hold_en);
    logic [7:0] exp_rem, exp_quo;
    int exp_lat, k;
    logic [7:0] prev_c;
    model(a, q, m, exp_rem, exp_quo, exp_lat);
    @(negedge clk); enable = 1'b1;
    @(posedge clk);
    @(negedge clk); enable = 1'b0; inbus = a;
    @(posedge clk);
    @(negedge clk); inbus = q;
    @(posedge clk);
    @(negedge clk); inbus = m;
    @(posedge clk);
    @(negedge clk);
    if (hold_en) enable = 1'b1;
    inbus = $urandom_range(0, 255);
    k = 3;
    prev_c = dut.c;
    while (!done && k < 30) begin
      prev_c = dut.c;
      @(posedge clk); k++;
      @(negedge clk);
      if (hold_en) inbus = $urandom_range(0, 255);
    end
    enable = 1'b0;
    chk({tag, " latency"}, k, exp_lat);
    chk({tag, " remainder"}, outbus, exp_rem);
    chk({tag, " c_before_done"}, prev_c, 8'h40);
    chk({tag, " c_first_done"}, dut.c, 8'h80);
    @(negedge clk);
    chk({tag, " done2"}, done, 1'b1);
    chk({tag, " quotient"}, outbus, exp_quo);
    chk({tag, " c_second_done"}, dut.c, 8'h00);
    @(negedge clk);
    chk({tag, " done_low"}, done, 1'b0);
    chk({tag, " outbus_idle"}, outbus, 8'h00);
  endtask

  initial begin
    logic [7:0] ra, rq, rm;
    rst_n = 1'b0; enable = 1'b0; inbus = 8'h00;
    #12;
    chk("reset outbus", outbus, 8'h00);
    chk("reset done", done, 1'b0);
    chk("reset c", dut.c, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle outbus", outbus, 8'h00);
    chk("idle c", dut.c, 8'h00);

    run_op("260/10", 8'd1, 8'd4, 8'd10, 1'b0);
    run_op("100/7", 8'd0, 8'd100, 8'd7, 1'b0);
    run_op("2559/10", 8'd9, 8'd255, 8'd10, 1'b0);
    run_op("255/1", 8'd0, 8'd255, 8'd1, 1'b0);
    run_op("ovf_a_eq_m", 8'd10, 8'd0, 8'd10, 1'b0);
    run_op("ovf_m0", 8'd0, 8'd5, 8'd0, 1'b0);
    run_op("hold_en", 8'd3, 8'd77, 8'd200, 1'b1);

    // Asynchronous reset in the middle of DIVIDE.
    @(negedge clk); enable = 1'b1;
    @(posedge clk);
    @(negedge clk); enable = 1'b0; inbus = 8'd2;
    @(posedge clk);
    @(negedge clk); inbus = 8'd50;
    @(posedge clk);
    @(negedge clk); inbus = 8'd9;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_divide c", dut.c, 8'h38);
    rst_n = 1'b0;
    #1;
    chk("rst_mid outbus", outbus, 8'h00);
    chk("rst_mid done", done, 1'b0);
    chk("rst_mid c", dut.c, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst done", done, 1'b0);
    run_op("after_rst", 8'd0, 8'd200, 8'd13, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rm = 8'($urandom_range(0, 255));
      rq = 8'($urandom_range(0, 255));
      if (i % 4 != 0 && rm != 0) ra = 8'($urandom_range(0, rm - 1));
      run_op($sformatf("rand%0d", i), ra, rq, rm, 1'(i % 3 == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
